csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 177 +++++++++++++++++
 tb/tb_csr_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file: trap/interrupt state, mtvec vectoring, 64-bit cycle/instret counters.
// Reads and the illegal flag are combinational; all state changes on the rising clk edge.
module csr_unit #(
    parameter int              XLEN      = 32,
    parameter int              CNT_WIDTH = 64,
    parameter logic [XLEN-1:0] HART_ID   = '0,
    parameter logic [XLEN-1:0] VENDOR_ID = 32'h6372_766d,
    parameter logic [XLEN-1:0] ARCH_ID   = 32'h6576_616d,
    parameter logic [XLEN-1:0] IMP_ID    = 32'h656e_7574
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            i_csr_en,
    input  logic [1:0]      i_csr_op,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_wdata,
    output logic [XLEN-1:0] o_csr_rdata,
    output logic            o_illegal,
    input  logic            i_timer_irq,
    input  logic            i_sw_irq,
    input  logic            i_ext_irq,
    input  logic            i_instr_retire,
    input  logic            i_trap_take,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic            i_mret,
    output logic            o_irq_pending,
    output logic [XLEN-1:0] o_irq_cause,
    output logic [XLEN-1:0] o_trap_vector,
    output logic [XLEN-1:0] o_mepc
);
    localparam logic [1:0]  OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;
    localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342;
    localparam logic [11:0] A_MIP = 12'h344, A_MCYCLE = 12'hB00, A_MCYCLEH = 12'hB80;
    localparam logic [11:0] A_MINSTRET = 12'hB02, A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11, A_MARCHID = 12'hF12;
    localparam logic [11:0] A_MIMPID = 12'hF13, A_MHARTID = 12'hF14;

    logic                 r_st_mie, r_st_mpie;
    logic [2:0]           r_mie, r_mip;          // {MEI, MTI, MSI}
    logic [XLEN-1:0]      r_mtvec, r_mscratch, r_mepc, r_mcause;
    logic [CNT_WIDTH-1:0] r_mcycle, r_minstret;

    logic            w_mapped, w_ro, w_wr_try, w_we;
    logic [XLEN-1:0] w_rdata, w_wval, w_base;
    logic [2:0]      w_pend;

    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        w_ro     = 1'b0;
        case (i_csr_addr)
            A_MSTATUS: begin
                w_rdata[3]     = r_st_mie;
                w_rdata[7]     = r_st_mpie;
                w_rdata[12:11] = 2'b11;
            end
            A_MIE: begin
                w_rdata[3]  = r_mie[0];
                w_rdata[7]  = r_mie[1];
                w_rdata[11] = r_mie[2];
            end
            A_MIP: begin
                w_rdata[3]  = r_mip[0];
                w_rdata[7]  = r_mip[1];
                w_rdata[11] = r_mip[2];
            end
            A_MTVEC:     w_rdata = r_mtvec;
            A_MSCRATCH:  w_rdata = r_mscratch;
            A_MEPC:      w_rdata = r_mepc;
            A_MCAUSE:    w_rdata = r_mcause;
            A_MCYCLE:    w_rdata = XLEN'(r_mcycle[31:0]);
            A_MCYCLEH:   w_rdata = XLEN'(r_mcycle[CNT_WIDTH-1:32]);
            A_MINSTRET:  w_rdata = XLEN'(r_minstret[31:0]);
            A_MINSTRETH: w_rdata = XLEN'(r_minstret[CNT_WIDTH-1:32]);
            A_MVENDORID: begin w_rdata = VENDOR_ID; w_ro = 1'b1; end
            A_MARCHID:   begin w_rdata = ARCH_ID;   w_ro = 1'b1; end
            A_MIMPID:    begin w_rdata = IMP_ID;    w_ro = 1'b1; end
            A_MHARTID:   begin w_rdata = HART_ID;   w_ro = 1'b1; end
            default:     w_mapped = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read and never counts as a write attempt.
    assign w_wr_try    = (i_csr_op == OP_RW) ||
                         ((i_csr_op == OP_RS || i_csr_op == OP_RC) && (|i_csr_wdata));
    assign o_illegal   = i_csr_en & (~w_mapped | (w_ro & w_wr_try));
    assign w_we        = i_csr_en & w_wr_try & ~o_illegal & ~i_trap_take;
    assign o_csr_rdata = w_rdata;

    always_comb begin
        case (i_csr_op)
            OP_RW:   w_wval = i_csr_wdata;
            OP_RS:   w_wval = w_rdata | i_csr_wdata;
            OP_RC:   w_wval = w_rdata & ~i_csr_wdata;
            default: w_wval = w_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_st_mie   <= 1'b0;
            r_st_mpie  <= 1'b0;
            r_mie      <= '0;
            r_mip      <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else begin
            r_mip <= {i_ext_irq, i_timer_irq, i_sw_irq};
            if (i_trap_take) begin
                r_st_mpie <= r_st_mie;
                r_st_mie  <= 1'b0;
                r_mepc    <= i_trap_pc & ~XLEN'(3);
                r_mcause  <= i_trap_cause;
            end else if (i_mret) begin
                r_st_mie  <= r_st_mpie;
                r_st_mpie <= 1'b1;
            end else if (w_we && i_csr_addr == A_MSTATUS) begin
                r_st_mie  <= w_wval[3];
                r_st_mpie <= w_wval[7];
            end
            if (w_we) begin
                case (i_csr_addr)
                    A_MIE:      r_mie      <= {w_wval[11], w_wval[7], w_wval[3]};
                    A_MTVEC:    r_mtvec    <= w_wval & ~XLEN'(2);
                    A_MSCRATCH: r_mscratch <= w_wval;
                    A_MEPC:     r_mepc     <= w_wval & ~XLEN'(3);
                    A_MCAUSE:   r_mcause   <= w_wval;
                    default:    ;
                endcase
            end
        end
    end

    // A write to either counter half replaces it and holds off that cycle's increment.
    always_ff @(posedge clk) begin
        if (arst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_we && i_csr_addr == A_MCYCLE)
                r_mcycle[31:0] <= w_wval[31:0];
            else if (w_we && i_csr_addr == A_MCYCLEH)
                r_mcycle[CNT_WIDTH-1:32] <= w_wval[CNT_WIDTH-33:0];
            else
                r_mcycle <= r_mcycle + 1'b1;

            if (w_we && i_csr_addr == A_MINSTRET)
                r_minstret[31:0] <= w_wval[31:0];
            else if (w_we && i_csr_addr == A_MINSTRETH)
                r_minstret[CNT_WIDTH-1:32] <= w_wval[CNT_WIDTH-33:0];
            else if (i_instr_retire)
                r_minstret <= r_minstret + 1'b1;
        end
    end

    assign w_pend        = r_mip & r_mie;
    assign o_irq_pending = r_st_mie & (|w_pend);
    assign o_mepc        = r_mepc;

    always_comb begin
        o_irq_cause = '0;
        if (o_irq_pending) begin
            o_irq_cause[XLEN-1] = 1'b1;
            if (w_pend[2])      o_irq_cause[3:0] = 4'd11;
            else if (w_pend[0]) o_irq_cause[3:0] = 4'd3;
            else                o_irq_cause[3:0] = 4'd7;
        end
    end

    assign w_base        = {r_mtvec[XLEN-1:2], 2'b00};
    assign o_trap_vector = (r_mtvec[0] && i_trap_cause[XLEN-1]) ?
                           w_base + {i_trap_cause[XLEN-3:0], 2'b00} : w_base;
endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed scenarios then random traffic, all checked against
// a behavioural model of the CSR file kept in plain variables.
module tb_csr_unit;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        en = 0, tmr = 0, sw = 0, ext = 0, ret = 0, trap = 0, mret = 0;
    logic [1:0]  op = 0;
    logic [11:0] addr = 0;
    logic [31:0] wdata = 0, tcause = 0, tpc = 0;
    logic [31:0] rdata, irq_cause, tvec, mepc;
    logic        illegal, irq_pend;

    int n_vec = 0, n_err = 0;

    // model state
    bit          m_mie = 0, m_mpie = 0;
    logic [31:0] m_mier = 0, m_mtvec = 0, m_mscr = 0, m_mepc = 0, m_mcause = 0, m_mip = 0;
    logic [63:0] m_cyc = 0, m_ins = 0;

    logic [11:0] addr_tab [18] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
        12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14,
        12'h7C0, 12'h301, 12'hB81};

    csr_unit dut (
        .clk(clk), .arst(arst), .i_csr_en(en), .i_csr_op(op), .i_csr_addr(addr),
        .i_csr_wdata(wdata), .o_csr_rdata(rdata), .o_illegal(illegal),
        .i_timer_irq(tmr), .i_sw_irq(sw), .i_ext_irq(ext), .i_instr_retire(ret),
        .i_trap_take(trap), .i_trap_cause(tcause), .i_trap_pc(tpc), .i_mret(mret),
        .o_irq_pending(irq_pend), .o_irq_cause(irq_cause), .o_trap_vector(tvec), .o_mepc(mepc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a, output bit mapped, output bit ro);
        mapped = 1; ro = 0;
        case (a)
            12'h300: return 32'h1800 | (m_mie ? 32'h8 : 0) | (m_mpie ? 32'h80 : 0);
            12'h304: return m_mier;
            12'h305: return m_mtvec;
            12'h340: return m_mscr;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            12'hF11: begin ro = 1; return 32'h6372_766d; end
            12'hF12: begin ro = 1; return 32'h6576_616d; end
            12'hF13: begin ro = 1; return 32'h656e_7574; end
            12'hF14: begin ro = 1; return 32'h0; end
            default: begin mapped = 0; return 32'h0; end
        endcase
    endfunction

    // Check every output at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        logic [31:0] old, nv, p, ecause, evec;
        logic [63:0] ncyc, nins;
        bit mp, ro, wtry, ill, epend, nmie, nmpie;
        @(negedge clk);
        old  = m_read(addr, mp, ro);
        wtry = (op == 2'd1) || (op != 2'd0 && wdata != 0);
        ill  = en && (!mp || (ro && wtry));
        chk("illegal", illegal, ill);
        if (mp) chk("rdata", rdata, old);
        p      = m_mip & m_mier;
        epend  = m_mie && (p != 0);
        ecause = !epend ? 32'h0 : p[11] ? 32'h8000000B : p[3] ? 32'h80000003 : 32'h80000007;
        chk("irq_pending", irq_pend, epend);
        chk("irq_cause", irq_cause, ecause);
        evec = m_mtvec & ~32'h3;
        if (m_mtvec[0] && tcause[31]) evec = evec + 32'(tcause[30:0]) * 4;
        chk("trap_vector", tvec, evec);
        chk("mepc", mepc, m_mepc);

        if (arst) begin
            m_mie = 0; m_mpie = 0; m_mier = 0; m_mtvec = 0; m_mscr = 0;
            m_mepc = 0; m_mcause = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
        end else begin
            ncyc = m_cyc + 1;
            nins = m_ins + (ret ? 64'd1 : 64'd0);
            nmie = m_mie; nmpie = m_mpie;
            if (en && wtry && !ill && !trap) begin
                nv = (op == 2'd1) ? wdata : (op == 2'd2) ? (old | wdata) : (old & ~wdata);
                case (addr)
                    12'h300: begin nmie = nv[3]; nmpie = nv[7]; end
                    12'h304: m_mier = nv & 32'h888;
                    12'h305: m_mtvec = nv & ~32'h2;
                    12'h340: m_mscr = nv;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    12'hB00: ncyc = {m_cyc[63:32], nv};
                    12'hB80: ncyc = {nv, m_cyc[31:0]};
                    12'hB02: nins = {m_ins[63:32], nv};
                    12'hB82: nins = {nv, m_ins[31:0]};
                    default: ;
                endcase
            end
            if (trap) begin
                m_mepc = tpc & ~32'h3; m_mcause = tcause; nmpie = m_mie; nmie = 0;
            end else if (mret) begin
                nmie = m_mpie; nmpie = 1;
            end
            m_mie = nmie; m_mpie = nmpie; m_cyc = ncyc; m_ins = nins;
            m_mip = (ext ? 32'h800 : 0) | (tmr ? 32'h80 : 0) | (sw ? 32'h8 : 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
        en = 1; op = o; addr = a; wdata = d;
    endtask

    task automatic rd(input logic [11:0] a);
        en = 0; op = 0; addr = a; wdata = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        tcause = 32'h8000_0005;
        #1;
        chk("rst_pend", irq_pend, 0);
        chk("rst_cause", irq_cause, 0);
        chk("rst_mepc", mepc, 0);
        chk("rst_tvec", tvec, 0);
        tcause = 0;
        arst = 0;
        rd(12'hB00);
        #1 chk("rst_mcycle0", rdata, 0);
        tick();
        chk("rst_mcycle1", rdata, 1);

        // timer interrupt enable path
        csr(2'd1, 12'h300, 32'h8); tick();
        csr(2'd2, 12'h304, 32'h80); tmr = 1; tick();
        rd(12'h300);
        #1 chk("t_pend", irq_pend, 1);
        chk("t_cause", irq_cause, 32'h80000007);
        tick();

        // priority, trap entry, mret
        csr(2'd1, 12'h304, 32'h888); sw = 1; ext = 1; tick();
        rd(12'h300); tick();
        chk("prio_ext", irq_cause, 32'h8000000B);
        ext = 0; tick();
        chk("prio_sw", irq_cause, 32'h80000003);
        trap = 1; tcause = 32'h80000003; tpc = 32'h2000; tick();
        trap = 0;
        #1 chk("trap_mstatus", rdata, 32'h1880);
        chk("trap_pend", irq_pend, 0);
        mret = 1; tick();
        mret = 0;
        #1 chk("mret_mstatus", rdata, 32'h1888);
        tmr = 0; sw = 0; tick();

        // vectored mtvec
        csr(2'd1, 12'h305, 32'h1003); tick();
        rd(12'h305); tcause = 32'h80000007;
        #1 chk("mtvec_rd", rdata, 32'h1001);
        chk("tvec_vect", tvec, 32'h101C);
        tcause = 32'h2;
        #1 chk("tvec_exc", tvec, 32'h1000);
        tick();

        // counter wrap
        csr(2'd1, 12'hB00, 32'hFFFF_FFFF); tick();
        csr(2'd1, 12'hB80, 32'hFFFF_FFFF); tick();
        rd(12'hB00);
        #1 chk("cyc_lo_ff", rdata, 32'hFFFF_FFFF);
        tick();
        chk("cyc_wrap", rdata, 0);
        tick();
        chk("cyc_inc", rdata, 1);

        // read-only and unmapped
        csr(2'd1, 12'hF14, 32'h5);
        #1 chk("ro_rw_ill", illegal, 1);
        tick();
        csr(2'd2, 12'hF14, 32'h0);
        #1 chk("ro_rs0_ill", illegal, 0);
        chk("hartid", rdata, 0);
        tick();
        csr(2'd0, 12'h7C0, 32'h0);
        #1 chk("unmapped_ill", illegal, 1);
        tick();

        // trap beats same-cycle mepc write
        csr(2'd1, 12'h341, 32'h5555); trap = 1; tpc = 32'h1237; tcause = 32'h2; tick();
        trap = 0; rd(12'h0);
        #1 chk("trap_mepc", mepc, 32'h1234);

        for (int i = 0; i < 600; i++) begin
            arst   = ($urandom_range(0, 79) == 0);
            en     = ($urandom_range(0, 2) != 0);
            op     = 2'($urandom_range(0, 3));
            addr   = addr_tab[$urandom_range(0, 17)];
            wdata  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            tmr    = $urandom_range(0, 1) != 0;
            sw     = $urandom_range(0, 1) != 0;
            ext    = $urandom_range(0, 3) == 0;
            ret    = $urandom_range(0, 1) != 0;
            trap   = $urandom_range(0, 11) == 0;
            mret   = $urandom_range(0, 7) == 0;
            tcause = {$urandom_range(0, 1) != 0, 27'($urandom_range(0, 3)), 4'($urandom)};
            tpc    = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
